// File: rtl/arrow_lane_scroller.sv
// Falling-arrow rhythm game lane: 8x4 arrow shift lane, key edge hit/wrong
// detection, clamped score and a miss counter that ends the game.
module arrow_lane_scroller #(
   parameter int SCORE_W    = 8,
   parameter int MISS_LIMIT = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [2:0]         i_row_sel,
   input  logic               i_step,
   input  logic [3:0]         i_new_arrow,
   input  logic [3:0]         i_key,
   input  logic               i_start,
   output logic [3:0]         o_row_data,
   output logic               o_hit,
   output logic               o_miss,
   output logic [SCORE_W-1:0] o_score,
   output logic               o_game_over
);

   // state  | meaning
   // IDLE   | after reset, waiting for START
   // PLAY   | lane scrolls, keys are scored
   // OVER   | miss limit reached, everything frozen until START
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_OVER = 2'd2;

   logic [1:0]         r_state;
   logic [3:0]         r_lane [8];
   logic [3:0]         r_key_prev;
   logic [3:0]         r_miss_cnt;
   logic [SCORE_W-1:0] r_score;
   logic               r_hit;
   logic               r_miss;
   logic [3:0]         r_row_data;

   logic                      w_play;
   logic [3:0]                w_edge;
   logic [3:0]                w_hit_bits;
   logic [3:0]                w_wrong_bits;
   logic [3:0]                w_missed;
   logic [3:0]                w_miss_inc;
   logic signed [SCORE_W+1:0] w_score_sum;
   logic [SCORE_W-1:0]        w_score_next;

   function automatic logic [SCORE_W+1:0] f_pop4(input logic [3:0] v);
      return (SCORE_W+2)'(v[0]) + (SCORE_W+2)'(v[1])
           + (SCORE_W+2)'(v[2]) + (SCORE_W+2)'(v[3]);
   endfunction

   assign w_play       = (r_state == S_PLAY);
   assign w_edge       = i_key & ~r_key_prev;
   assign w_hit_bits   = w_edge & r_lane[7];
   assign w_wrong_bits = w_edge & ~r_lane[7];
   // arrows hit on the same edge as a step are removed before they can count as missed
   assign w_missed     = i_step ? (r_lane[7] & ~w_hit_bits) : 4'd0;
   assign w_miss_inc   = r_miss_cnt + 4'd1;

   assign w_score_sum = $signed({2'b00, r_score}) + $signed(f_pop4(w_hit_bits))
                      - $signed(f_pop4(w_wrong_bits));

   always_comb begin
      w_score_next = w_score_sum[SCORE_W-1:0];
      if (w_score_sum < 0)
         w_score_next = '0;
      else if (w_score_sum > $signed({2'b00, {SCORE_W{1'b1}}}))
         w_score_next = {SCORE_W{1'b1}};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         for (int i = 0; i < 8; i++) r_lane[i] <= 4'd0;
         r_key_prev <= 4'b1111;
         r_miss_cnt <= 4'd0;
         r_score    <= '0;
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         r_row_data <= 4'd0;
      end else begin
         r_key_prev <= i_key;
         r_row_data <= r_lane[i_row_sel];
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         if (i_start) begin
            r_state    <= S_PLAY;
            for (int i = 0; i < 8; i++) r_lane[i] <= 4'd0;
            r_miss_cnt <= 4'd0;
            r_score    <= '0;
         end else if (w_play) begin
            r_hit   <= |w_hit_bits;
            r_miss  <= |w_missed;
            r_score <= w_score_next;
            if (i_step) begin
               for (int i = 7; i > 0; i--) r_lane[i] <= r_lane[i-1];
               r_lane[0] <= i_new_arrow;
            end else begin
               r_lane[7] <= r_lane[7] & ~w_hit_bits;
            end
            if (|w_missed) begin
               r_miss_cnt <= w_miss_inc;
               if (w_miss_inc == 4'(MISS_LIMIT))
                  r_state <= S_OVER;
            end
         end
      end
   end

   assign o_row_data  = r_row_data;
   assign o_hit       = r_hit;
   assign o_miss      = r_miss;
   assign o_score     = r_score;
   assign o_game_over = (r_state == S_OVER);

endmodule

// File: doc/arrow_lane_scroller.md
ARROW_LANE_SCROLLER -- requirements
Module: arrow_lane_scroller

Interface
REQ-001 Parameter SCORE_W, default 8, SHALL set the width of SCORE.
REQ-002 Parameter MISS_LIMIT, default 4, SHALL set the number of missed steps that ends a game (legal range 1..15).
REQ-003 CLOCK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 ROW_SEL  input  3  current display scan row from the upstream 3-bit row counter (0 = top, 7 = bottom).
REQ-006 STEP  input  1  one-cycle pulse that advances the lane one row.
REQ-007 NEW_ARROW  input  4  arrow pattern injected into row 0 on STEP (bit k = lane k).
REQ-008 KEY  input  4  player buttons, already synchronized, level-sensitive, 1 = pressed.
REQ-009 START  input  1  one-cycle pulse that starts or restarts a game.
REQ-010 ROW_DATA  output  4  arrows in row ROW_SEL, registered.
REQ-011 HIT  output  1  one-cycle pulse when at least one arrow is hit.
REQ-012 MISS  output  1  one-cycle pulse when at least one arrow leaves row 7 unhit.
REQ-013 SCORE  output  SCORE_W  current score.
REQ-014 GAME_OVER  output  1  high while in state OVER.

Function
REQ-015 Lane storage SHALL be 8 rows x 4 bits; row 7 is the hit row.
REQ-016 States SHALL be IDLE, PLAY and OVER; START in any state SHALL go to PLAY and clear lane, score and miss count on that edge.
REQ-017 In IDLE and OVER, STEP and KEY SHALL be ignored; lane, SCORE and miss count SHALL hold.
REQ-018 In PLAY, on STEP: row[i] <= row[i-1] for i = 1..7, and row[0] <= NEW_ARROW.
REQ-019 Key edge vector SHALL be KEY & ~KEY_prev, with KEY_prev registered every cycle in all states.
REQ-020 In PLAY, hit bits = edge & row7 and wrong bits = edge & ~row7, both taken from row 7 before any same-cycle shift.
REQ-021 Hit bits SHALL be cleared from row 7 in the same edge; when STEP coincides, the cleared bits SHALL NOT count as missed.
REQ-022 Missed bits on STEP = row7 & ~hit bits; MISS SHALL pulse the cycle after any STEP with nonzero missed bits.
REQ-023 HIT SHALL pulse the cycle after any cycle with nonzero hit bits; HIT and MISS may both be high in the same cycle.
REQ-024 SCORE next = SCORE + popcount(hit bits) - popcount(wrong bits), clamped to [0, 2^SCORE_W - 1].
REQ-025 Miss count SHALL increment by 1 per STEP with missed bits, not per arrow.
REQ-026 When the miss count reaches MISS_LIMIT, the FSM SHALL enter OVER on that edge and assert GAME_OVER from the next cycle.
REQ-027 ROW_DATA SHALL equal the lane row indexed by ROW_SEL, registered every cycle in all states (1-cycle latency), reflecting the lane contents before that edge's update.

Reset
REQ-028 With RESET = 0, the block SHALL immediately set: state IDLE; lane all 0; SCORE 0; miss count 0; ROW_DATA 0; HIT, MISS and GAME_OVER 0; KEY_prev 4'b1111, so a key held through reset does not register as a press.
REQ-029 Reset asserted mid-game SHALL abort the game with no pending HIT or MISS pulse emitted after release.
REQ-030 After RESET returns to 1, the block SHALL stay in IDLE until START.

Verification
REQ-031 START, then 8 STEPs with NEW_ARROW = 4'b0001 on the first step only -> ROW_DATA at ROW_SEL = 7 reads 4'b0001 after step 8.
REQ-032 Arrow 4'b0101 in row 7, KEY 0000 -> 0101 -> HIT pulses 1 cycle, SCORE +2, row 7 reads 0000, no MISS on the next STEP.
REQ-033 Row 7 = 4'b0010 with a KEY rising edge 0000 -> 0010 on the same cycle as STEP -> HIT = 1, MISS = 0, SCORE +1.
REQ-034 SCORE = 0 and a wrong press 0000 -> 1000 -> SCORE stays 0; SCORE = 255 (SCORE_W = 8) and a hit -> SCORE stays 255.
REQ-035 MISS_LIMIT = 4 and four STEPs each dropping an unhit arrow -> 4 MISS pulses, GAME_OVER = 1, then further STEP/KEY changes lane and SCORE not at all; START -> PLAY with SCORE = 0.
REQ-036 KEY = 1111 held through RESET release and START -> no HIT, no SCORE change; RESET pulsed low mid-game -> all outputs 0 asynchronously, state IDLE.
